fifo8x16: RTL

- 8-entry × 16-bit synchronous FIFO with a show-ahead read port.
- The read path is one mux8way16 instance, with the 3-bit read pointer driving its select.
- Sits between a 16-bit producer (e.g. I/O or memory-mapped input) and the CPU datapath, buffering words across short stalls.
- Storage is eight 16-bit registers; pointers and occupancy count are sequential.

---
 rtl/fifo8x16.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo8x16.sv
// 8-entry x 16-bit show-ahead FIFO with a mux8way16 read path.
// Optional sticky err output enabled by defining FIFO8X16_ERR_EN.

module mux8way16 (
  input  logic [7:0][15:0] in,
  input  logic [2:0]       sel,
  output logic [15:0]      out
);

  // One-hot decode of the select onto the eight words
  always_comb begin
    out = 16'h0000;
    unique case (1'b1)
      (sel == 3'd0): out = in[0];
      (sel == 3'd1): out = in[1];
      (sel == 3'd2): out = in[2];
      (sel == 3'd3): out = in[3];
      (sel == 3'd4): out = in[4];
      (sel == 3'd5): out = in[5];
      (sel == 3'd6): out = in[6];
      (sel == 3'd7): out = in[7];
      default:       out = 16'h0000;
    endcase
  end

endmodule

module fifo8x16 #(
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] wr_data,
  input  logic        pop,
  output logic [15:0] rd_data,
  output logic        full,
  output logic        empty,
  output logic        almost_full,
  output logic        almost_empty,
`ifdef FIFO8X16_ERR_EN
  output logic        err,
`endif
  output logic [3:0]  count
);

  localparam logic [3:0] AF = AF_LEVEL[3:0];
  localparam logic [3:0] AE = AE_LEVEL[3:0];

  logic [7:0][15:0] mem_q, mem_d;
  logic [2:0]       wr_ptr_q, wr_ptr_d;
  logic [2:0]       rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             push_ok, pop_ok;
  logic [15:0]      head;

  // Flags decode straight from the occupancy register
  always_comb begin
    full         = (count_q == 4'd8);
    empty        = (count_q == 4'd0);
    almost_full  = (count_q >= AF);
    almost_empty = (count_q <= AE);
    count        = count_q;
  end

  // Acceptance: a pop frees the slot a full-FIFO push needs
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 3'd1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 3'd1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage words carry no reset; stale data is masked by count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  mux8way16 u_rd_mux (
    .in  (mem_q),
    .sel (rd_ptr_q),
    .out (head)
  );

  // Show-ahead head word, zeroed while empty
  always_comb begin
    rd_data = empty ? 16'h0000 : head;
  end

`ifdef FIFO8X16_ERR_EN
  logic err_q, err_d;

  // Sticky record of any dropped request
  always_comb begin
    err_d = err_q
          | (push & full & ~pop_ok)
          | (pop & empty);
  end

  // Error flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
